// File: rtl/matrix_out_clamp_pkg.sv
// Shared colour-pipeline helpers: input width, rounding, clamping, clip flags.
package matrix_out_clamp_pkg;

    // Internal arithmetic width; wide enough for any practical W+1.
    localparam int CALC_W = 64;

    localparam logic CLIP    = 1'b1;
    localparam logic NO_CLIP = 1'b0;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_e;

    localparam int NUM_CH = 3;

    // Multiplier output width: sign + overflow bits + pixel bits + 1 fraction bit.
    function automatic int in_width(input int dsize, input int nsize);
        return dsize + nsize + 2;
    endfunction

    // Drop the half-LSB fraction bit, rounding half up (towards +inf).
    function automatic logic signed [CALC_W-1:0] round_half_up(input logic signed [CALC_W-1:0] x);
        return (x + 64'sd1) >>> 1;
    endfunction

    function automatic logic signed [CALC_W-1:0] max_pixel(input int dsize);
        return (64'sd1 <<< dsize) - 64'sd1;
    endfunction

    // Saturate a signed integer into [0, 2^dsize-1].
    function automatic logic signed [CALC_W-1:0] clamp_unsigned(input logic signed [CALC_W-1:0] r,
                                                                 input int dsize);
        if (r < 64'sd0)
            return '0;
        else if (r > max_pixel(dsize))
            return max_pixel(dsize);
        else
            return r;
    endfunction

    // Flag whether clamp_unsigned had to saturate.
    function automatic logic clamp_clip(input logic signed [CALC_W-1:0] r, input int dsize);
        return ((r < 64'sd0) || (r > max_pixel(dsize))) ? CLIP : NO_CLIP;
    endfunction

endpackage

// File: rtl/matrix_out_clamp_sync_delay_line.sv
// Fixed-depth shift register for video syncs; DEPTH=0 is a plain wire.
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] pipe;

            // Shift one stage per clock; reset flushes to all-zero syncs.
            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= din;
                    for (int i = 1; i < DEPTH; i++)
                        pipe[i] <= pipe[i-1];
                end
            end

            assign dout = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/matrix_out_clamp.sv
// Colour matrix output stage: round, saturate, realign syncs, count clipped pixels per frame.
module matrix_out_clamp
    import matrix_out_clamp_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int NSIZE = 1,
    parameter int MLAT  = 5,
    parameter int CSIZE = 24
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [DSIZE+NSIZE+1:0]   iR,
    input  logic [DSIZE+NSIZE+1:0]   iG,
    input  logic [DSIZE+NSIZE+1:0]   iB,
    input  logic                     in_vs,
    input  logic                     in_hs,
    input  logic                     in_de,
    output logic [DSIZE-1:0]         oR,
    output logic [DSIZE-1:0]         oG,
    output logic [DSIZE-1:0]         oB,
    output logic                     o_vs,
    output logic                     o_hs,
    output logic                     o_de,
    output logic [CSIZE-1:0]         clip_cnt,
    output logic                     clip_vld
);

    localparam int W = in_width(DSIZE, NSIZE);
    localparam logic [CSIZE-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0][W-1:0]     x_in;
    logic [NUM_CH-1:0][W:0]       r1;
    logic [NUM_CH-1:0][W:0]       r1_next;
    logic [NUM_CH-1:0][DSIZE-1:0] pix_next;
    logic [NUM_CH-1:0]            clip_ch;
    logic [2:0]                   sync_d;
    logic                         de_al;
    logic                         count_px;
    logic                         frame_rise;
    logic [CSIZE-1:0]             run_cnt;

    assign x_in = {iB, iG, iR};

    // Syncs leave the delay line aligned with the stage-1 register; stage 2 adds the last clock.
    sync_delay_line #(
        .DEPTH (MLAT + 1),
        .WIDTH (3)
    ) u_sync (
        .clock (clock),
        .rst   (rst),
        .din   ({in_vs, in_hs, in_de}),
        .dout  (sync_d)
    );

    // Per-channel rounding (into stage 1) and saturation (into stage 2).
    always_comb begin
        r1_next  = '0;
        pix_next = '0;
        clip_ch  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            r1_next[c]  = (W+1)'(round_half_up(CALC_W'(signed'(x_in[c]))));
            pix_next[c] = DSIZE'(clamp_unsigned(CALC_W'(signed'(r1[c])), DSIZE));
            clip_ch[c]  = clamp_clip(CALC_W'(signed'(r1[c])), DSIZE);
        end
    end

    assign de_al      = sync_d[0];
    assign count_px   = de_al & (|clip_ch);
    // o_vs holds the previous aligned vs, so this is a rising edge only.
    assign frame_rise = sync_d[2] & ~o_vs;

    // Stage 1: rounded channel values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            r1 <= '0;
        else
            r1 <= r1_next;
    end

    // Stage 2: clamped pixels blanked outside active video, plus aligned syncs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            oR   <= '0;
            oG   <= '0;
            oB   <= '0;
            o_vs <= 1'b0;
            o_hs <= 1'b0;
            o_de <= 1'b0;
        end else begin
            oR   <= de_al ? pix_next[CH_R] : '0;
            oG   <= de_al ? pix_next[CH_G] : '0;
            oB   <= de_al ? pix_next[CH_B] : '0;
            o_vs <= sync_d[2];
            o_hs <= sync_d[1];
            o_de <= de_al;
        end
    end

    // Saturating clip counter; a frame edge publishes it and restarts with the edge pixel.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            run_cnt  <= '0;
            clip_cnt <= '0;
            clip_vld <= 1'b0;
        end else begin
            clip_vld <= frame_rise;
            if (frame_rise) begin
                clip_cnt <= run_cnt;
                run_cnt  <= CSIZE'(count_px);
            end else if (count_px && run_cnt != CNT_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_out_clamp.sv
// Directed bench for matrix_out_clamp; a second instance with CSIZE=4 checks counter saturation.
module tb_matrix_out_clamp;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [10:0] iR, iG, iB;
    logic        in_vs, in_hs, in_de;
    logic [7:0]  oR, oG, oB;
    logic        o_vs, o_hs, o_de;
    logic [23:0] clip_cnt;
    logic        clip_vld;

    logic [7:0]  s_oR, s_oG, s_oB;
    logic        s_vs, s_hs, s_de;
    logic [3:0]  s_cnt;
    logic        s_vld;

    int total = 0;
    int bad   = 0;

    // Models the multiplier latency: data for a sync issued now arrives 5 calls later.
    logic [32:0] dq[$];

    always #5 clock = ~clock;

    matrix_out_clamp #(.DSIZE(8), .NSIZE(1), .MLAT(5), .CSIZE(24)) dut (
        .clock(clock), .rst(rst), .iR(iR), .iG(iG), .iB(iB),
        .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de),
        .oR(oR), .oG(oG), .oB(oB), .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
        .clip_cnt(clip_cnt), .clip_vld(clip_vld)
    );

    matrix_out_clamp #(.DSIZE(8), .NSIZE(1), .MLAT(5), .CSIZE(4)) dut_s (
        .clock(clock), .rst(rst), .iR(iR), .iG(iG), .iB(iB),
        .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de),
        .oR(s_oR), .oG(s_oG), .oB(s_oB), .o_vs(s_vs), .o_hs(s_hs), .o_de(s_de),
        .clip_cnt(s_cnt), .clip_vld(s_vld)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic px(input logic vs, input logic hs, input logic de,
                      input logic [10:0] r, input logic [10:0] g, input logic [10:0] b);
        logic [32:0] d;
        in_vs = vs;
        in_hs = hs;
        in_de = de;
        dq.push_back({r, g, b});
        if (dq.size() > 5) begin
            d = dq.pop_front();
            {iR, iG, iB} = d;
        end else begin
            {iR, iG, iB} = '0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        px(1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 11'd0);
    endtask

    // One de pixel, then check it at the output 7 clocks after its sync.
    task automatic pix_chk(input string tag, input logic [10:0] r, input logic [10:0] g,
                           input logic [10:0] b, input int er, input int eg, input int eb);
        px(1'b0, 1'b0, 1'b1, r, g, b);
        repeat (6) idle();
        chk({tag, "_de"}, int'(o_de), 1);
        chk({tag, "_r"}, int'(oR), er);
        chk({tag, "_g"}, int'(oG), eg);
        chk({tag, "_b"}, int'(oB), eb);
    endtask

    // vs high for 'hold' calls (first may carry a de pixel), then check the report.
    task automatic frame_edge(input string tag, input int hold, input logic de,
                              input logic [10:0] r, input int exp_m, input int exp_s);
        px(1'b1, 1'b0, de, r, 11'd0, 11'd0);
        for (int k = 1; k <= 8; k++) begin
            if (k < hold) px(1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 11'd0);
            else idle();
            if (k == 5) chk({tag, "_vld_pre"}, int'(clip_vld), 0);
            if (k == 6) begin
                chk({tag, "_vs"}, int'(o_vs), 1);
                chk({tag, "_vld"}, int'(clip_vld), 1);
                chk({tag, "_cnt"}, int'(clip_cnt), exp_m);
                chk({tag, "_cnt4"}, int'(s_cnt), exp_s);
            end
            if (k >= 7) chk({tag, "_vld_post"}, int'(clip_vld), 0);
        end
    endtask

    initial begin
        {iR, iG, iB} = '0;
        in_vs = 1'b0;
        in_hs = 1'b0;
        in_de = 1'b0;

        // Reset state
        #12;
        chk("rst_de", int'(o_de), 0);
        chk("rst_vs", int'(o_vs), 0);
        chk("rst_r", int'(oR), 0);
        chk("rst_cnt", int'(clip_cnt), 0);
        chk("rst_vld", int'(clip_vld), 0);
        @(posedge clock);
        #1;
        rst = 1'b0;

        // Latency: de at call 0, data 5 calls later, both out at call 7
        px(1'b0, 1'b1, 1'b1, 11'd200, 11'd0, 11'd0);
        for (int k = 1; k <= 8; k++) begin
            idle();
            chk("lat_de", int'(o_de), (k == 6) ? 1 : 0);
            chk("lat_hs", int'(o_hs), (k == 6) ? 1 : 0);
            chk("lat_r", int'(oR), (k == 6) ? 100 : 0);
        end

        // First edge after reset, vs held 3 cycles: one pulse, count 0
        frame_edge("edge0", 3, 1'b0, 11'd0, 0, 0);

        // Rounding and saturation (3 clipping pixels)
        pix_chk("round", 11'd509, 11'd3, 11'h7FF, 255, 2, 0);
        pix_chk("sat_r", 11'd511, 11'd0, 11'd0, 255, 0, 0);
        pix_chk("sat_g", 11'd0, 11'd1023, 11'd0, 0, 255, 0);
        pix_chk("sat_b", 11'd0, 11'd0, 11'h7FD, 0, 0, 0);
        pix_chk("bound", 11'd510, 11'd0, 11'd0, 255, 0, 0);
        frame_edge("edge1", 1, 1'b0, 11'd0, 3, 3);

        // 100-pixel frame with 7 clips; edge pixel clips but belongs to the next frame
        for (int i = 0; i < 100; i++) begin
            if (i == 50)
                px(1'b0, 1'b0, 1'b1, 11'd511, 11'd1023, 11'h7FD);
            else if (i == 3 || i == 10 || i == 20)
                px(1'b0, 1'b0, 1'b1, 11'd511, 11'd0, 11'd0);
            else if (i == 21 || i == 77 || i == 99)
                px(1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 11'h7FD);
            else
                px(1'b0, 1'b0, 1'b1, 11'(2 * i), 11'(i), 11'd0);
        end
        frame_edge("edge100", 1, 1'b1, 11'd511, 7, 7);

        // Next frame: edge pixel plus 2 clips
        px(1'b0, 1'b0, 1'b1, 11'd511, 11'd0, 11'd0);
        idle();
        px(1'b0, 1'b0, 1'b1, 11'd0, 11'd1023, 11'd0);
        frame_edge("edge_sim", 1, 1'b0, 11'd0, 3, 3);

        // 20 clips: narrow counter saturates at 15
        for (int i = 0; i < 20; i++)
            px(1'b0, 1'b0, 1'b1, 11'd600, 11'd0, 11'd0);
        frame_edge("edge_sat", 1, 1'b0, 11'd0, 20, 15);

        // Mid-line async reset with clipping pixels in flight
        for (int i = 0; i < 10; i++)
            px(1'b0, 1'b0, 1'b1, 11'd511, 11'd0, 11'd0);
        #3;
        chk("pre_rst_de", int'(o_de), 1);
        chk("pre_rst_r", int'(oR), 255);
        rst = 1'b1;
        #1;
        chk("mid_rst_de", int'(o_de), 0);
        chk("mid_rst_r", int'(oR), 0);
        chk("mid_rst_cnt", int'(clip_cnt), 0);
        idle();
        idle();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3 || k == 8)
                px(1'b0, 1'b0, 1'b1, 11'd511, 11'd10, 11'd10);
            else
                px(1'b0, 1'b0, 1'b1, 11'd10, 11'd10, 11'd10);
            chk("post_rst_de", int'(o_de), (k >= 7) ? 1 : 0);
        end
        frame_edge("edge_rst", 1, 1'b0, 11'd0, 2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_out_clamp.md
Name: matrix_out_clamp

Overview:
- Output stage directly downstream of the 3x3 colour matrix multiplier.
- Takes the three signed, one-fraction-bit channel results (sign + overflow integer bits + DSIZE bits + 1 fraction bit) and rounds them to DSIZE-bit unsigned pixels, saturating to the legal range.
- Delays the video syncs, sampled at the multiplier input, by the multiplier latency plus its own latency, so syncs and pixels leave aligned.
- Counts clipped pixels per frame for gain-tuning firmware.

Parameters:
- DSIZE, 8, output pixel width per channel; matches the multiplier DSIZE.
- NSIZE, 1, extra integer-overflow bits in the multiplier output; input width W = DSIZE+NSIZE+2.
- MLAT, 5, multiplier pipeline latency in clocks.
- CSIZE, 24, clip-counter width.

Ports:
- clock  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous, active-high.
- iR  in  W  two's-complement R result from the multiplier; LSB = 1/2 output LSB.
- iG  in  W  G result, same format.
- iB  in  W  B result, same format.
- in_vs  in  1  vsync, active-high, sampled alongside the pixel entering the multiplier.
- in_hs  in  1  hsync, active-high, same timing.
- in_de  in  1  data enable, same timing.
- oR  out  DSIZE  clamped R pixel.
- oG  out  DSIZE  clamped G pixel.
- oB  out  DSIZE  clamped B pixel.
- o_vs  out  1  vsync aligned to oR/oG/oB.
- o_hs  out  1  hsync aligned to the pixels.
- o_de  out  1  data enable aligned to the pixels.
- clip_cnt  out  CSIZE  clipped-pixel count of the previous frame.
- clip_vld  out  1  one-cycle pulse when clip_cnt updates.

Behaviour:
- Reset (async assert, sync release): all outputs 0; sync delay line, running counter and clip_cnt cleared to 0.
- Stage 1 (registered), per channel: r = (x + 1) >>> 1 (arithmetic shift, round half up). Computed in W+1 bits so x = 2^(W-1)-1 cannot overflow.
- Stage 2 (registered), per channel: r < 0 gives 0 and flags clip; r > 2^DSIZE-1 gives 2^DSIZE-1 and flags clip; otherwise r[DSIZE-1:0]. Pixel clip = OR of the three channel flags.
- Data latency: 2 clocks from iR/iG/iB to oR/oG/oB.
- Sync latency: in_vs/in_hs/in_de reach o_vs/o_hs/o_de after exactly MLAT+2 clocks. The delay line is a shift register and must support MLAT >= 0.
- oR/oG/oB are forced to 0 in any cycle where the aligned de is 0.
- Running counter:
  - Increments by 1 on each cycle where aligned de=1 and the pixel clips.
  - Saturates at 2^CSIZE-1; no wrap.
- Frame boundary = rising edge of the aligned vs (vs=1 this cycle, 0 the previous cycle). On that cycle:
  - clip_cnt <= running count.
  - clip_vld = 1 for that cycle only.
  - Running counter restarts at 1 if the same cycle holds a clipped de pixel, otherwise at 0.
- The first vs edge after reset reports whatever was counted since reset (normally 0).
- vs held high does not retrigger; only rising edges count.
- Reset mid-frame discards the partial count; the pipeline refills with zeros, and o_de stays 0 for MLAT+2 cycles.

Decomposition:
- Shared package (colour pipeline): W width function, round_half_up and clamp_unsigned functions, clip-flag constant names.
- One sub-module, sync_delay_line: parameters DEPTH and WIDTH, async active-high reset, used here for {vs,hs,de}.
- Channel rounding/clamp is a package function instantiated three times; no separate module.

Test Plan:
- Latency check (DSIZE=8, NSIZE=1, MLAT=5): in_de pulses at cycle 0 -> o_de=1 at cycle 7 only. iR=200 at cycle 5 -> oR=100 at cycle 7.
- Rounding: iR=509 (254.5) -> 255, no clip. iG=3 (1.5) -> 2. iB=0x7FF (-0.5) -> 0, no clip.
- Saturation: iR=511 -> 255 with clip. iG=1023 -> 255 with clip. iB=0x7FD (-1.5) -> 0 with clip. Boundary iR=510 -> 255, no clip.
- Clip counting: a frame of 100 de pixels, 7 of them clipping (including a pixel where all three channels clip) -> clip_cnt=7 and clip_vld for 1 cycle at the next aligned vs rising edge.
- Simultaneous events: a clipped de pixel on the same cycle as the vs rising edge -> reported count excludes it; the next frame reports 1 plus later clips. CSIZE=4 with 20 clips -> clip_cnt=15.
- Async reset asserted mid-line -> all outputs 0 immediately. After release, o_de stays 0 for 7 cycles, and the next vs edge reports only post-reset clips.
